event_fifo_reader: RTL and testbench

EVENT_FIFO_READER -- requirements
Module: event_fifo_reader

---
 rtl/event_fifo_reader_pkg.sv | 14 +
 rtl/out_skid_fifo.sv | 43 ++++
 rtl/event_fifo_reader.sv | 82 ++++++++
 tb/tb_event_fifo_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/event_fifo_reader_pkg.sv
// event_fifo_reader_pkg: tag codes, FSM state type and output buffer word layout shared by the event reader
package event_fifo_reader_pkg;
  localparam logic [1:0] TAG_HDR = 2'b10;
  localparam logic [1:0] TAG_SMP = 2'b00;
  localparam logic [1:0] TAG_TRL = 2'b01;
  localparam logic [1:0] TAG_RSV = 2'b11;
  typedef enum logic {WAIT_HDR, PAYLOAD} state_t;
  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] data;
  } buf_word_t;
  localparam int BUF_W = $bits(buf_word_t);
endpackage

// File: rtl/out_skid_fifo.sv
// out_skid_fifo: small valid/ready FIFO used as the reader's output buffer
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : write side
//   out_valid/out_ready/out_data  : read side; out_data is zero while empty
//   occupancy                     : number of stored entries
module out_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready  = occupancy != CW'(DEPTH);
  assign out_valid = occupancy != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      occupancy <= occupancy + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/event_fifo_reader.sv
// event_fifo_reader: reads tagged words from an event FIFO, checks framing, forwards SOF/EOF-marked payload
//   Clock, Reset          : clock, synchronous active-high reset
//   Enable                : permits new FIFO reads
//   FIFO_Empty/FIFO_Q/FIFO_RE : event FIFO read port, data one cycle after FIFO_RE
//   Out_Valid/Out_Ready/Out_Data/Out_SOF/Out_EOF : output stream
//   Busy                  : inside an event (PAYLOAD)
//   Event_Count           : completed events delivered, wraps
//   Format_Error/Clear_Error : sticky framing error and its clear
module event_fifo_reader
  import event_fifo_reader_pkg::*;
#(
  parameter int g_CountWidth = 16,
  parameter int g_BufDepth   = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    FIFO_Empty,
  input  logic [17:0]             FIFO_Q,
  output logic                    FIFO_RE,
  input  logic                    Out_Ready,
  output logic                    Out_Valid,
  output logic [15:0]             Out_Data,
  output logic                    Out_SOF,
  output logic                    Out_EOF,
  output logic                    Busy,
  output logic [g_CountWidth-1:0] Event_Count,
  output logic                    Format_Error,
  input  logic                    Clear_Error
);
  localparam int OW = $clog2(g_BufDepth+1);
  state_t state, state_nx;
  logic rd_pend, cap, pop, push, err_set, in_ready;
  logic [1:0] tag;
  logic [OW-1:0] occ;
  logic [OW:0] fill;
  buf_word_t in_word, out_word;
  assign tag  = FIFO_Q[17:16];
  // a word read before Reset is dropped because capture is gated by Reset
  assign cap  = rd_pend & ~Reset;
  assign pop  = Out_Valid & Out_Ready;
  // every read in flight reserves a slot, so the buffer can never overflow
  assign fill = {1'b0, occ} + (OW+1)'(rd_pend) - (OW+1)'(pop);
  assign FIFO_RE = Enable & ~FIFO_Empty & ~Reset & (fill < (OW+1)'(g_BufDepth));
  always_ff @(posedge Clock)
    state <= Reset ? WAIT_HDR : state_nx;
  always_comb
    state_nx = !cap ? state :
               (state == WAIT_HDR && tag == TAG_HDR) ? PAYLOAD :
               (state == PAYLOAD && tag == TAG_TRL) ? WAIT_HDR : state;
  always_comb begin
    push    = cap & in_ready & (tag == TAG_HDR | (state == PAYLOAD & tag != TAG_RSV));
    err_set = cap & (tag == TAG_RSV | (state == WAIT_HDR & tag != TAG_HDR) | (state == PAYLOAD & tag == TAG_HDR));
    in_word = '{sof: tag == TAG_HDR, eof: tag == TAG_TRL, data: FIFO_Q[15:0]};
    Busy    = state == PAYLOAD;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_pend      <= 1'b0;
      Event_Count  <= '0;
      Format_Error <= 1'b0;
    end else begin
      rd_pend      <= FIFO_RE;
      Event_Count  <= Event_Count + g_CountWidth'(pop & Out_EOF);
      Format_Error <= err_set | (Format_Error & ~Clear_Error);
    end
  end
  out_skid_fifo #(.DEPTH(g_BufDepth), .WIDTH(BUF_W)) u_buf (
    .clk       (Clock),
    .rst       (Reset),
    .in_valid  (push),
    .in_ready  (in_ready),
    .in_data   (in_word),
    .out_valid (Out_Valid),
    .out_ready (Out_Ready),
    .out_data  (out_word),
    .occupancy (occ)
  );
  assign Out_SOF  = out_word.sof;
  assign Out_EOF  = out_word.eof;
  assign Out_Data = out_word.data;
endmodule

// File: tb/tb_event_fifo_reader.sv
// tb_event_fifo_reader: directed tests for event_fifo_reader with a behavioural event FIFO
module tb_event_fifo_reader;
  localparam int CW = 4;
  localparam int DEPTH = 2;
  logic Clock = 1'b0, Reset = 1'b1, Enable = 1'b0, FIFO_Empty = 1'b1, Out_Ready = 1'b0, Clear_Error = 1'b0;
  logic [17:0] FIFO_Q = '0;
  logic FIFO_RE, Out_Valid, Out_SOF, Out_EOF, Busy, Format_Error;
  logic [15:0] Out_Data;
  logic [CW-1:0] Event_Count;
  event_fifo_reader #(.g_CountWidth(CW), .g_BufDepth(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .FIFO_Empty(FIFO_Empty), .FIFO_Q(FIFO_Q),
    .FIFO_RE(FIFO_RE), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_SOF(Out_SOF), .Out_EOF(Out_EOF), .Busy(Busy), .Event_Count(Event_Count),
    .Format_Error(Format_Error), .Clear_Error(Clear_Error)
  );
  always #5 Clock = ~Clock;
  int total = 0, bad = 0, cyc = 0, reads = 0, xfers = 0, bad_re = 0, unstable = 0, valid_seen = 0;
  int first_re = -1, first_ov = -1;
  logic [17:0] src[$];
  logic [17:0] got[$];
  int got_cyc[$];
  logic held = 1'b0, pend;
  logic [17:0] held_w;

  // one clock: sample outputs 1 time unit after the negedge, then advance to the next negedge
  task automatic step();
    #1;
    if (held && (!Out_Valid || {Out_SOF, Out_EOF, Out_Data} !== held_w)) unstable++;
    held   = Out_Valid & ~Out_Ready;
    held_w = {Out_SOF, Out_EOF, Out_Data};
    pend   = FIFO_RE;
    if (FIFO_RE) begin
      reads++;
      if (src.size() == 0) bad_re++;
      if (first_re < 0) first_re = cyc;
    end
    if (Out_Valid) begin
      valid_seen++;
      if (first_ov < 0) first_ov = cyc;
    end
    if (Out_Valid && Out_Ready) begin
      xfers++;
      got.push_back(held_w);
      got_cyc.push_back(cyc);
    end
    @(negedge Clock);
    cyc++;
    if (pend && src.size() > 0) FIFO_Q = src.pop_front();
    FIFO_Empty = src.size() == 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [17:0] w);
    src.push_back(w);
    FIFO_Empty = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b1; Out_Ready = 1'b1;
    load(18'h2AAAA);
    run(3);
    #1;
    total++; if (FIFO_RE !== 1'b0) begin bad++; $display("FAIL reset_re got=%b exp=0", FIFO_RE); end
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Out_Valid); end
    total++; if ({Out_SOF, Out_EOF, Out_Data} !== 18'h0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {Out_SOF, Out_EOF, Out_Data}); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (Event_Count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Event_Count); end
    total++; if (Format_Error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", Format_Error); end
    total++; if (reads !== 0) begin bad++; $display("FAIL reset_no_reads got=%0d exp=0", reads); end
    Reset = 1'b0; src.delete(); FIFO_Empty = 1'b1;
    run(2);
  endtask

  task automatic test_basic();
    logic [17:0] exp_w [6] = '{18'h2A5A5, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h100FF};
    int b = got.size();
    Enable = 1'b1; Out_Ready = 1'b1; first_re = -1; first_ov = -1;
    foreach (exp_w[i]) load(exp_w[i]);
    run(15);
    total++; if (got.size() - b != 6) begin bad++; $display("FAIL basic_count got=%0d exp=6", got.size() - b); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[b+i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, got[b+i], exp_w[i]); end
    end
    total++; if (got_cyc[b+5] - got_cyc[b] != 5) begin bad++; $display("FAIL basic_contig got=%0d exp=5", got_cyc[b+5] - got_cyc[b]); end
    total++; if (first_ov - first_re != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", first_ov - first_re); end
    total++; if (Event_Count !== 4'd1) begin bad++; $display("FAIL basic_events got=%0d exp=1", Event_Count); end
    total++; if (Format_Error !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", Format_Error); end
  endtask

  task automatic test_toggle();
    logic [17:0] exp_w [6] = '{18'h2A5A5, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h100FF};
    int b = got.size(), r0 = reads, x0 = xfers, u0 = unstable, e0 = bad_re, ovf = 0;
    foreach (exp_w[i]) load(exp_w[i]);
    for (int i = 0; i < 30; i++) begin
      Out_Ready = (i % 2) == 0;
      step();
      if ((reads - r0) - (xfers - x0) > DEPTH) ovf++;
    end
    Out_Ready = 1'b1;
    run(3);
    total++; if (got.size() - b != 6) begin bad++; $display("FAIL toggle_count got=%0d exp=6", got.size() - b); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[b+i] !== exp_w[i]) begin bad++; $display("FAIL toggle_word%0d got=%h exp=%h", i, got[b+i], exp_w[i]); end
    end
    total++; if (ovf != 0) begin bad++; $display("FAIL toggle_overflow got=%0d exp=0", ovf); end
    total++; if (unstable - u0 != 0) begin bad++; $display("FAIL toggle_stable got=%0d exp=0", unstable - u0); end
    total++; if (bad_re - e0 != 0) begin bad++; $display("FAIL toggle_re_empty got=%0d exp=0", bad_re - e0); end
    total++; if (Event_Count !== 4'd2) begin bad++; $display("FAIL toggle_events got=%0d exp=2", Event_Count); end
  endtask

  task automatic test_err_before_hdr();
    int b = got.size(), v0 = valid_seen;
    Out_Ready = 1'b1;
    load(18'h01234);
    run(6);
    total++; if (got.size() != b) begin bad++; $display("FAIL orphan_out got=%0d exp=0", got.size() - b); end
    total++; if (valid_seen != v0) begin bad++; $display("FAIL orphan_valid got=%0d exp=0", valid_seen - v0); end
    total++; if (Format_Error !== 1'b1) begin bad++; $display("FAIL orphan_err got=%b exp=1", Format_Error); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL orphan_busy got=%b exp=0", Busy); end
    Clear_Error = 1'b1; step(); Clear_Error = 1'b0;
    #1;
    total++; if (Format_Error !== 1'b0) begin bad++; $display("FAIL clear_err got=%b exp=0", Format_Error); end
    load(18'h01235);
    step();
    Clear_Error = 1'b1; step(); Clear_Error = 1'b0;
    #1;
    total++; if (Format_Error !== 1'b1) begin bad++; $display("FAIL clear_vs_set got=%b exp=1", Format_Error); end
    Clear_Error = 1'b1; step(); Clear_Error = 1'b0;
    run(2);
  endtask

  task automatic test_restart();
    logic [17:0] in_w [6] = '{18'h20011, 18'h00021, 18'h00022, 18'h20012, 18'h00023, 18'h10024};
    logic [17:0] exp_w [6] = '{18'h20011, 18'h00021, 18'h00022, 18'h20012, 18'h00023, 18'h10024};
    int b = got.size();
    foreach (in_w[i]) load(in_w[i]);
    run(12);
    total++; if (got.size() - b != 6) begin bad++; $display("FAIL restart_count got=%0d exp=6", got.size() - b); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[b+i] !== exp_w[i]) begin bad++; $display("FAIL restart_word%0d got=%h exp=%h", i, got[b+i], exp_w[i]); end
    end
    total++; if (Format_Error !== 1'b1) begin bad++; $display("FAIL restart_err got=%b exp=1", Format_Error); end
    total++; if (Event_Count !== 4'd3) begin bad++; $display("FAIL restart_events got=%0d exp=3", Event_Count); end
    Clear_Error = 1'b1; step(); Clear_Error = 1'b0;
  endtask

  task automatic test_reserved();
    logic [17:0] exp_w [3] = '{18'h20032, 18'h00033, 18'h10034};
    int b = got.size();
    load(18'h10031);
    load(18'h20032);
    run(5);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rsv_busy got=%b exp=1", Busy); end
    load(18'h3BEEF); load(18'h00033); load(18'h30000); load(18'h10034);
    run(10);
    total++; if (got.size() - b != 3) begin bad++; $display("FAIL rsv_count got=%0d exp=3", got.size() - b); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got[b+i] !== exp_w[i]) begin bad++; $display("FAIL rsv_word%0d got=%h exp=%h", i, got[b+i], exp_w[i]); end
    end
    total++; if (Format_Error !== 1'b1) begin bad++; $display("FAIL rsv_err got=%b exp=1", Format_Error); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rsv_idle got=%b exp=0", Busy); end
    total++; if (Event_Count !== 4'd4) begin bad++; $display("FAIL rsv_events got=%0d exp=4", Event_Count); end
    Clear_Error = 1'b1; step(); Clear_Error = 1'b0;
  endtask

  task automatic test_enable();
    logic [17:0] exp_w [5] = '{18'h20041, 18'h00042, 18'h00043, 18'h00044, 18'h10045};
    int b = got.size(), r0 = reads;
    Enable = 1'b0; Out_Ready = 1'b1;
    foreach (exp_w[i]) load(exp_w[i]);
    run(5);
    total++; if (reads != r0) begin bad++; $display("FAIL en_off_reads got=%0d exp=0", reads - r0); end
    Out_Ready = 1'b0; Enable = 1'b1;
    run(6);
    total++; if (reads - r0 != 2) begin bad++; $display("FAIL en_full_reads got=%0d exp=2", reads - r0); end
    Enable = 1'b0; Out_Ready = 1'b1;
    run(6);
    total++; if (got.size() - b != 2) begin bad++; $display("FAIL en_drain got=%0d exp=2", got.size() - b); end
    total++; if (src.size() != 3) begin bad++; $display("FAIL en_left got=%0d exp=3", src.size()); end
    Enable = 1'b1;
    run(8);
    total++; if (got.size() - b != 5) begin bad++; $display("FAIL en_count got=%0d exp=5", got.size() - b); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got[b+i] !== exp_w[i]) begin bad++; $display("FAIL en_word%0d got=%h exp=%h", i, got[b+i], exp_w[i]); end
    end
    total++; if (Event_Count !== 4'd5) begin bad++; $display("FAIL en_events got=%0d exp=5", Event_Count); end
  endtask

  task automatic test_wrap();
    Reset = 1'b1; src.delete(); FIFO_Empty = 1'b1;
    run(2);
    Reset = 1'b0; Enable = 1'b1; Out_Ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      load(18'h20000 + 18'(i));
      load(18'h10000 + 18'(i));
    end
    run(40);
    total++; if (Event_Count !== 4'd15) begin bad++; $display("FAIL wrap_preset got=%0d exp=15", Event_Count); end
    load(18'h20100); load(18'h10101);
    run(6);
    total++; if (Event_Count !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", Event_Count); end
  endtask

  task automatic test_reset_mid();
    int b, v0;
    load(18'h20070); load(18'h10071);
    run(6);
    Out_Ready = 1'b0;
    load(18'h00050); load(18'h20051); load(18'h00052); load(18'h00053);
    run(3);
    #1;
    total++; if ({Busy, Format_Error, Out_Valid} !== 3'b111) begin bad++; $display("FAIL mid_pre got=%b exp=111", {Busy, Format_Error, Out_Valid}); end
    Reset = 1'b1; src.delete(); FIFO_Empty = 1'b1;
    step();
    #1;
    total++; if ({FIFO_RE, Out_Valid, Out_SOF, Out_EOF, Busy, Format_Error} !== 6'b0) begin bad++; $display("FAIL mid_flags got=%b exp=000000", {FIFO_RE, Out_Valid, Out_SOF, Out_EOF, Busy, Format_Error}); end
    total++; if (Out_Data !== 16'h0) begin bad++; $display("FAIL mid_data got=%h exp=0", Out_Data); end
    total++; if (Event_Count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", Event_Count); end
    Reset = 1'b0;
    v0 = valid_seen;
    run(3);
    total++; if (valid_seen != v0) begin bad++; $display("FAIL mid_inflight got=%0d exp=0", valid_seen - v0); end
    b = got.size();
    Out_Ready = 1'b1;
    load(18'h20061); load(18'h10062);
    run(6);
    total++; if (got.size() - b != 2) begin bad++; $display("FAIL mid_new_count got=%0d exp=2", got.size() - b); end
    total++; if (got[b] !== 18'h20061) begin bad++; $display("FAIL mid_new_hdr got=%h exp=20061", got[b]); end
    total++; if (got[b+1] !== 18'h10062) begin bad++; $display("FAIL mid_new_trl got=%h exp=10062", got[b+1]); end
    total++; if (Event_Count !== 4'd1) begin bad++; $display("FAIL mid_new_events got=%0d exp=1", Event_Count); end
    total++; if (Format_Error !== 1'b0) begin bad++; $display("FAIL mid_new_err got=%b exp=0", Format_Error); end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_basic();
    test_toggle();
    test_err_before_hdr();
    test_restart();
    test_reserved();
    test_enable();
    test_wrap();
    test_reset_mid();
    total++; if (bad_re != 0) begin bad++; $display("FAIL re_when_empty got=%0d exp=0", bad_re); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
